// File: rtl/mux_2to1_3bit.sv
`default_nettype none
// ============================================================================
// Module   : mux_2to1_3bit
// Purpose  : 3-bit wide 2:1 multiplexer. SELECT=0 passes IN1, SELECT=1
//            passes IN2; all three bits switch together, unmodified.
// Build    : Macro MUX_2TO1_3BIT_REG_OUT_EN selects the output style.
//              undefined (default) : OUT is purely combinational, CLK and
//                                    RESET are ignored.
//              defined             : OUT is registered on rising CLK with
//                                    one cycle of latency; an active-low
//                                    asynchronous RESET forces RESET_VALUE.
// Params   : RESET_VALUE [2:0] - OUT value while RESET is low (registered
//                                build only), default 3'b000.
// Ports    : IN1    [2:0] in  - data chosen when SELECT = 0
//            IN2    [2:0] in  - data chosen when SELECT = 1
//            OUT    [2:0] out - selected data
//            SELECT       in  - 0 -> IN1, 1 -> IN2
//            CLK          in  - clock, rising edge
//            RESET        in  - asynchronous reset, active low
//            Positional order IN1, IN2, OUT, SELECT keeps legacy four-port
//            instantiations working; CLK and RESET were appended after them.
// Revision : 1.0 - initial release
// ============================================================================
module mux_2to1_3bit #(
  parameter logic [2:0] RESET_VALUE = 3'b000
) (
  input  logic [2:0] IN1,
  input  logic [2:0] IN2,
  output logic [2:0] OUT,
  input  logic       SELECT,
  input  logic       CLK,
  input  logic       RESET
);

  // Selected value. The conditional operator is used on purpose: with an
  // unknown SELECT it merges the two operands bitwise, so bits on which IN1
  // and IN2 agree stay known and only differing bits become X.
  logic [2:0] sel_d;

  always_comb begin
    sel_d = SELECT ? IN2 : IN1;
  end

`ifdef MUX_2TO1_3BIT_REG_OUT_EN

  // Output register. Reset is asynchronous so OUT drops to RESET_VALUE the
  // moment RESET falls, discarding whatever was about to be loaded.
  logic [2:0] out_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out_q <= RESET_VALUE;
    end else begin
      out_q <= sel_d;
    end
  end

  assign OUT = out_q;

`else

  // Combinational build: no state at all. CLK, RESET and RESET_VALUE exist
  // only so both builds share one port list; fold them into a sink so they
  // are visibly intentional rather than forgotten.
  logic w_unused;

  assign w_unused = ^{CLK, RESET, RESET_VALUE};
  assign OUT      = sel_d;

`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_2to1_3bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_2to1_3bit
// Purpose  : Self-checking bench for mux_2to1_3bit. Follows whichever build
//            MUX_2TO1_3BIT_REG_OUT_EN selects. The reference model picks the
//            expected value by indexing a two-entry array of the inputs with
//            SELECT; the registered build keeps a one-deep history of it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_2to1_3bit;

  logic [2:0] in1;
  logic [2:0] in2;
  logic [2:0] out;
  logic       sel;
  logic       clk;
  logic       rst_n;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] C_RESET_VALUE = 3'b000;

  mux_2to1_3bit #(
    .RESET_VALUE(C_RESET_VALUE)
  ) dut (
    .IN1   (in1),
    .IN2   (in2),
    .OUT   (out),
    .SELECT(sel),
    .CLK   (clk),
    .RESET (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the data inputs as an array indexed by the select bit.
  function automatic logic [2:0] model(input logic [2:0] a, input logic [2:0] b,
                                       input logic s);
    logic [2:0] choices [2];
    choices[0] = a;
    choices[1] = b;
    return choices[s];
  endfunction

  task automatic check(input string tag, input logic [2:0] exp);
    checks++;
    assert (out === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, out, exp);
    end
  endtask

  // Compare only the bits set in mask (used where the rest may be unknown).
  task automatic check_masked(input string tag, input logic [2:0] exp,
                              input logic [2:0] mask);
    checks++;
    assert ((out & mask) === (exp & mask))
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b mask=%b", tag, out, exp, mask);
    end
  endtask

  initial begin
    logic [2:0] a;
    logic [2:0] b;
    logic       s;
    logic [2:0] exp_q;

    in1   = 3'b000;
    in2   = 3'b000;
    sel   = 1'b0;
    rst_n = 1'b0;

`ifdef MUX_2TO1_3BIT_REG_OUT_EN
    // ---------------- registered build ----------------
    in1 = 3'b011;
    #1;
    check("rst_async", C_RESET_VALUE);
    repeat (2) @(negedge clk);
    check("rst_hold", C_RESET_VALUE);

    // Release between edges: nothing loads until the next rising edge.
    rst_n = 1'b1;
    #1;
    check("rst_release_pre_edge", C_RESET_VALUE);
    @(posedge clk); #1;
    check("first_edge_load", 3'b011);

    // Alternate SELECT every cycle; each edge shows the value set up before it.
    in1 = 3'b111;
    in2 = 3'b001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sel   = i[0];
      exp_q = model(in1, in2, sel);
      @(posedge clk); #1;
      check("toggle_seq", exp_q);
      // A change between edges must not reach OUT.
      in1 = 3'b010;
      in2 = 3'b100;
      #1;
      check("hold_between_edges", exp_q);
      in1 = 3'b111;
      in2 = 3'b001;
    end

    // Random traffic, inputs and select changing together every cycle.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a     = 3'($urandom);
      b     = 3'($urandom);
      s     = 1'($urandom);
      in1   = a;
      in2   = b;
      sel   = s;
      exp_q = model(a, b, s);
      @(posedge clk); #1;
      check("rand_reg", exp_q);
    end

    // Mid-stream reset while OUT holds 3'b111.
    @(negedge clk);
    in1 = 3'b111;
    sel = 1'b0;
    @(posedge clk); #1;
    check("pre_midreset", 3'b111);
    in1 = 3'b101;            // pending value that reset must discard
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_async", C_RESET_VALUE);
    @(posedge clk); #1;
    check("midreset_hold", C_RESET_VALUE);
    @(negedge clk);
    rst_n = 1'b1;
    in1   = 3'b010;
    @(posedge clk); #1;
    check("midreset_release", 3'b010);

    // Unknown select: agreeing bits 2 and 0 must be 1 and 0.
    @(negedge clk);
    in1 = 3'b110;
    in2 = 3'b100;
    sel = 1'bx;
    @(posedge clk); #1;
    check_masked("sel_x_reg", 3'b100, 3'b101);
`else
    // ---------------- combinational build ----------------
    rst_n = 1'b1;
    in1   = 3'b101;
    in2   = 3'b000;
    sel   = 1'b0;
    #1;
    check("dir_sel0", 3'b101);
    sel = 1'b1;
    #1;
    check("dir_sel1", 3'b000);

    // Exhaustive sweep of all input pairs with both selects.
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 2; j++) begin
        a   = 3'(i);
        b   = 3'(i >> 3);
        s   = j[0];
        in1 = a;
        in2 = b;
        sel = s;
        #1;
        check("sweep", model(a, b, s));
      end
    end

    // Unknown select: bits where IN1 and IN2 agree remain known.
    in1 = 3'b110;
    in2 = 3'b100;
    sel = 1'bx;
    #1;
    check_masked("sel_x", 3'b100, 3'b101);

    // Reset and clock have no effect; output follows inputs immediately.
    rst_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      a   = 3'($urandom);
      b   = 3'($urandom);
      s   = 1'($urandom);
      in1 = a;
      in2 = b;
      sel = s;
      #1;
      check("rand_in_reset", model(a, b, s));
      @(posedge clk); #1;
      check("rand_after_edge", model(a, b, s));
    end
    rst_n = 1'b1;
    #1;
    check("reset_release_no_effect", model(a, b, s));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_2to1_3bit.md
MUX_2TO1_3BIT -- requirements
Module: mux_2to1_3bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports and parameters are listed below.
REQ-002 Parameter RESET_VALUE, default 3'b000: value driven on OUT while reset is asserted (registered build only).
REQ-003 Port CLK, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 Port RESET, input, 1 bit: asynchronous reset; active when low.
REQ-005 Port IN1, input, 3 bits: data input selected when SELECT = 0.
REQ-006 Port IN2, input, 3 bits: data input selected when SELECT = 1.
REQ-007 Port OUT, output, 3 bits: selected data.
REQ-008 Port SELECT, input, 1 bit: 0 selects IN1, 1 selects IN2.
REQ-009 Positional port order SHALL be IN1, IN2, OUT, SELECT, CLK, RESET.
REQ-010 The first four positions SHALL stay compatible with existing four-port positional instantiations.

Function
REQ-011 The selected value SHALL be IN1 when SELECT = 0.
REQ-012 The selected value SHALL be IN2 when SELECT = 1.
REQ-013 All 3 bits SHALL be selected together; there is no per-bit select.
REQ-014 The block SHALL apply no arithmetic, inversion, widening or truncation to the selected value.
REQ-015 If SELECT is X or Z, each OUT bit SHALL equal the matching IN1/IN2 bit where those bits agree and SHALL be X where they differ.
REQ-016 Combinational build: OUT SHALL follow the selected value with zero clock latency and no state.
REQ-017 Combinational build: a change on IN1, IN2 or SELECT SHALL reach OUT in the same delta/timestep.
REQ-018 Registered build: OUT SHALL load the selected value on each rising CLK edge while RESET is high.
REQ-019 Registered build: the value on OUT SHALL be the one sampled at the previous edge, giving one-cycle latency.
REQ-020 Registered build: changes between edges SHALL NOT affect OUT.
REQ-021 Registered build: if SELECT and the inputs change in the same cycle, OUT SHALL be computed from the values present at the edge.

Reset
REQ-022 In the registered build, OUT SHALL take RESET_VALUE immediately when RESET goes low, independent of CLK.
REQ-023 OUT SHALL hold RESET_VALUE while RESET stays low.
REQ-024 The first rising edge after RESET goes high SHALL load the selected value.
REQ-025 Reset asserted mid-stream SHALL discard any pending value.
REQ-026 In the combinational build, CLK and RESET SHALL be ignored.

Configuration
REQ-027 Macro MUX_2TO1_3BIT_REG_OUT_EN SHALL select between the two builds.
REQ-028 With MUX_2TO1_3BIT_REG_OUT_EN defined, OUT SHALL be registered as in REQ-018 to REQ-025.
REQ-029 With MUX_2TO1_3BIT_REG_OUT_EN undefined, OUT SHALL be purely combinational as in REQ-016 and REQ-017; this is the default build.
REQ-030 Both builds SHALL have identical port lists.

Verification
REQ-031 Combinational build, IN1=3'b101, IN2=3'b000: SELECT=0 -> OUT=3'b101; SELECT=1 -> OUT=3'b000.
REQ-032 Combinational build, sweep all 64 IN1/IN2 pairs with both SELECT values -> OUT equals the chosen input in every case.
REQ-033 Combinational build, SELECT=1'bx, IN1=3'b110, IN2=3'b100 -> OUT=3'b1x0.
REQ-034 Registered build, hold RESET low -> OUT=3'b000; release RESET with IN1=3'b011, SELECT=0 -> OUT=3'b011 after the first rising edge.
REQ-035 Registered build, toggle SELECT every cycle with IN1=3'b111, IN2=3'b001 -> OUT shows the alternating sequence delayed by exactly one cycle.
REQ-036 Registered build, pull RESET low between edges while OUT=3'b111 -> OUT=3'b000 before the next edge.
